mod_counter_ps: RTL and testbench
=================================

Name: mod_counter_ps

Overview:
- Parametrised modulo-N up/down counter with an integrated clock-enable prescaler.
- Successor to the fixed 8-bit free-running counter. Adds configurable width, modulus, count rate, direction, load, synchronous clear, wrap/saturate mode and a terminal-count pulse.
- Drives display digit counters, timebases (e.g. PRESCALE=500,000,000 for 0.1 Hz at 50 MHz) and FSM step sequencers in the lab designs.

Parameters:
- WIDTH, 8, counter width in bits; legal range 1..32.
- MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- PRESCALE, 1, clock cycles per count step; legal range 1..2^32-1; 1 means a step on every enabled cycle.
- SATURATE, 0, 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; gates both the prescaler and the counter.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on step cycles.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- d  in  WIDTH  load value.
- q  out  WIDTH  counter value (registered).
- tc  out  1  terminal-count pulse (registered, one cycle).
- tick  out  1  prescaler step strobe (combinational from prescaler state and en).
- at_max  out  1  q == MODULUS-1 (combinational from q).
- at_zero  out  1  q == 0 (combinational from q).

Behaviour:
- Reset (reset=0, asynchronous): q=0, tc=0, prescaler phase p=0. Release is synchronous to clk. After release, at_zero=1 and tick=0 until en rises.
- Prescaler:
  - Phase register p, width clog2(PRESCALE), minimum 1 bit.
  - When en=1: tick = (p == PRESCALE-1); p advances to p+1, wrapping to 0 after PRESCALE-1.
  - When en=0: p holds and tick=0.
  - PRESCALE=1: p is unused and tick = en.
- Per-edge priority (highest first):
  1. clr: q=0, p=0, tc=0.
  2. load: q = min(d, MODULUS-1), p=0, tc=0.
  3. tick=1: step q.
  4. Otherwise: q holds, tc=0.
- Step, up=1:
  - q < MODULUS-1: q=q+1.
  - q == MODULUS-1 and SATURATE=0: q=0, tc=1.
  - q == MODULUS-1 and SATURATE=1: q holds, tc=1.
- Step, up=0:
  - q > 0: q=q-1.
  - q == 0 and SATURATE=0: q=MODULUS-1, tc=1.
  - q == 0 and SATURATE=1: q holds, tc=1.
- tc timing: tc is high for exactly the one cycle that shows the post-step q. In saturate mode it re-pulses on every step attempted at the bound.
- Latency: a step appears on q one clock after the tick cycle. The first step after en rises (p=0) occurs PRESCALE cycles later.
- Arithmetic: all compares are unsigned at WIDTH bits, with MODULUS-1 cast to WIDTH. MODULUS = 2^WIDTH wraps naturally with no extra logic.
- Direction change on a non-step cycle has no effect. Changing up mid-prescale does not reset p.
- Elaboration: MODULUS or PRESCALE outside its legal range fails elaboration via a generate-time error.

Decomposition:
- Package mod_counter_pkg holds:
  - function clog2_min1(n)
  - constants for the legal limits, MAX_WIDTH=32
  - a mode encoding localparam pair: MODE_WRAP=0, MODE_SAT=1
- Sub-module clk_en_prescaler (PRESCALE):
  - Ports clk, reset, en, sync_clr, tick.
  - sync_clr is driven by (clr | load).
  - Reusable standalone as a timebase for other lab blocks.

Test Plan (WIDTH=4, MODULUS=10, PRESCALE=3, SATURATE=0 unless noted):
- Reset: assert reset=0 mid-count at q=7 -> q=0, tc=0 immediately with no clock edge; after release with en=1, first step to q=1 occurs on the 3rd edge.
- Up wrap: en=1, up=1 from q=0 -> q increments every 3 cycles through 9; next step gives q=0 with tc=1 for one cycle; 30 cycles produce exactly one tc.
- Down wrap: load d=0, up=0 -> next step gives q=9 with tc=1; then 8, 7 on subsequent ticks.
- Load and clear priority:
  - load d=12 -> q=9 (clamped).
  - clr=1 and load=1 together with d=5 -> q=0.
  - load while tick=1 -> loaded value wins; p restarts, so the next step is 3 cycles later.
- Saturate (SATURATE=1): at q=9, up=1, 4 ticks -> q stays 9 with tc pulsed 4 times; up=0 -> q=8 with tc=0.
- Edges:
  - PRESCALE=1, MODULUS=16: q counts every cycle 15 -> 0 with tc=1.
  - en toggled 0 for 5 cycles mid-phase -> p frozen, and the step slips by exactly 5 cycles.

Source files
------------

// File: rtl/mod_counter_ps_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mod_counter_pkg
//  Brief   : Shared limits, mode encoding and sizing helper for mod_counter_ps.
//  Revision: 1.0
// ============================================================================
package mod_counter_pkg;

  localparam int              MIN_WIDTH    = 1;
  localparam int              MAX_WIDTH    = 32;
  localparam longint unsigned MIN_MODULUS  = 2;
  localparam longint unsigned MIN_PRESCALE = 1;
  localparam longint unsigned MAX_PRESCALE = 64'h0000_0000_FFFF_FFFF;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Bits needed to hold 0..n-1, never less than one so a register always exists.
  function automatic int clog2_min1(input longint unsigned n);
    int r;
    r = 0;
    while ((64'd1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter_ps_if.sv
`default_nettype none
// ============================================================================
//  Module  : mod_counter_ps_if
//  Brief   : Control/status bundle between a counter user and mod_counter_ps.
//  Revision: 1.0
// ============================================================================
interface mod_counter_ps_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             tick;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en, up, clr, load, d,
    input  q, tc, tick, at_max, at_zero
  );

  modport slave (
    input  en, up, clr, load, d,
    output q, tc, tick, at_max, at_zero
  );

endinterface
`default_nettype wire

// File: rtl/mod_counter_ps_clk_en_prescaler.sv
`default_nettype none
// ============================================================================
//  Module  : clk_en_prescaler
//  Brief   : Divides enabled clock cycles by PRESCALE into a one-cycle tick.
//  Revision: 1.0
// ============================================================================
module clk_en_prescaler
  import mod_counter_pkg::*;
#(
  parameter longint unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int              c_PW     = clog2_min1(PRESCALE);
  localparam logic [c_PW-1:0] c_P_LAST = c_PW'(PRESCALE - 1);

  if (PRESCALE < MIN_PRESCALE || PRESCALE > MAX_PRESCALE) begin : g_bad_prescale
    $error("clk_en_prescaler: PRESCALE out of range");
  end

  logic [c_PW-1:0] r_p;
  logic            w_last;

  // With PRESCALE=1 the phase never leaves zero, so tick reduces to en.
  assign w_last = (r_p == c_P_LAST);
  assign tick   = en & w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p <= '0;
    end else if (sync_clr) begin
      r_p <= '0;
    end else if (en) begin
      r_p <= w_last ? '0 : r_p + c_PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_counter_ps.sv
`default_nettype none
// ============================================================================
//  Module  : mod_counter_ps
//  Brief   : Modulo-N up/down counter with load, clear, wrap/saturate and prescaler.
//  Revision: 1.0
// ============================================================================
module mod_counter_ps
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter longint unsigned PRESCALE = 1,
  parameter bit              SATURATE = MODE_WRAP
) (
  input  logic               clk,
  input  logic               reset,
  mod_counter_ps_if.slave    bus
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mod_counter_ps: WIDTH out of range");
  end
  if (MODULUS < MIN_MODULUS || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter_ps: MODULUS out of range");
  end

  localparam logic [WIDTH-1:0] c_Q_MAX = WIDTH'(MODULUS - 1);
  localparam bit               c_HOLD  = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;
  logic             w_tick;
  logic             w_sync_clr;

  assign w_sync_clr = bus.clr | bus.load;

  clk_en_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .sync_clr (w_sync_clr),
    .tick     (w_tick)
  );

  always_comb begin
    w_q_next  = r_q;
    w_tc_next = 1'b0;
    if (bus.clr) begin
      w_q_next = '0;
    end else if (bus.load) begin
      w_q_next = (bus.d > c_Q_MAX) ? c_Q_MAX : bus.d;
    end else if (w_tick) begin
      if (bus.up) begin
        if (r_q == c_Q_MAX) begin
          w_tc_next = 1'b1;
          w_q_next  = c_HOLD ? r_q : '0;
        end else begin
          w_q_next  = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_tc_next = 1'b1;
          w_q_next  = c_HOLD ? r_q : c_Q_MAX;
        end else begin
          w_q_next  = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_next;
      r_tc <= w_tc_next;
    end
  end

  assign bus.q       = r_q;
  assign bus.tc      = r_tc;
  assign bus.tick    = w_tick;
  assign bus.at_max  = (r_q == c_Q_MAX);
  assign bus.at_zero = (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_mod_counter_ps.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mod_counter_ps
//  Brief   : Scoreboard bench: wrap (M=10,P=3), saturate (M=10,P=3), fast (M=16,P=1).
//  Revision: 1.0
// ============================================================================
module tb_mod_counter_ps;

  logic clk;
  logic reset;

  mod_counter_ps_if #(.WIDTH(4)) if0 ();
  mod_counter_ps_if #(.WIDTH(4)) if1 ();
  mod_counter_ps_if #(.WIDTH(4)) if2 ();

  mod_counter_ps #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  mod_counter_ps #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  mod_counter_ps #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(1'b0))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       mx;
    logic       z;
  } exp_t;

  exp_t sb[3][$];

  int unsigned M[3] = '{10, 10, 16};
  int unsigned P[3] = '{3, 3, 1};
  bit          S[3] = '{1'b0, 1'b1, 1'b0};

  int unsigned mq[3];
  int unsigned mp[3];
  bit          mtc[3];

  bit         s_rst, s_en, s_up, s_clr, s_load;
  logic [3:0] s_d;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic drive(input bit e, input bit u, input bit c, input bit l, input logic [3:0] dd);
    s_en = e; s_up = u; s_clr = c; s_load = l; s_d = dd;
    if0.en = e; if0.up = u; if0.clr = c; if0.load = l; if0.d = dd;
    if1.en = e; if1.up = u; if1.clr = c; if1.load = l; if1.d = dd;
    if2.en = e; if2.up = u; if2.clr = c; if2.load = l; if2.d = dd;
  endtask

  // Counter behaviour stated as plain integer arithmetic on count and phase.
  task automatic model_edge();
    bit tk;
    for (int i = 0; i < 3; i++) begin
      if (!s_rst) begin
        mq[i] = 0; mp[i] = 0; mtc[i] = 1'b0;
      end else if (s_clr) begin
        mq[i] = 0; mp[i] = 0; mtc[i] = 1'b0;
      end else if (s_load) begin
        mq[i] = (s_d > M[i] - 1) ? M[i] - 1 : s_d;
        mp[i] = 0; mtc[i] = 1'b0;
      end else begin
        tk     = s_en && (mp[i] == P[i] - 1);
        mtc[i] = 1'b0;
        if (s_en) mp[i] = (mp[i] + 1) % P[i];
        if (tk) begin
          if (s_up) begin
            if (mq[i] == M[i] - 1) begin mtc[i] = 1'b1; if (!S[i]) mq[i] = 0; end
            else mq[i] = mq[i] + 1;
          end else begin
            if (mq[i] == 0) begin mtc[i] = 1'b1; if (!S[i]) mq[i] = M[i] - 1; end
            else mq[i] = mq[i] - 1;
          end
        end
      end
      sb[i].push_back('{q: 4'(mq[i]), tc: mtc[i], mx: (mq[i] == M[i] - 1), z: (mq[i] == 0)});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  function automatic logic [7:0] act(input int i);
    case (i)
      0:       return {if0.q, if0.tc, if0.tick, if0.at_max, if0.at_zero};
      1:       return {if1.q, if1.tc, if1.tick, if1.at_max, if1.at_zero};
      default: return {if2.q, if2.tc, if2.tick, if2.at_max, if2.at_zero};
    endcase
  endfunction

  // Monitor: registered outputs compared half a cycle after each edge.
  always @(negedge clk) begin
    exp_t e;
    bit   tk;
    for (int i = 0; i < 3; i++) begin
      if (sb[i].size() > 0) begin
        e  = sb[i].pop_front();
        tk = s_en && (mp[i] == P[i] - 1);
        check($sformatf("dut%0d {q,tc,tick,max,zero}", i), 32'(act(i)),
              32'({e.q, e.tc, tk, e.mx, e.z}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int cnt;
    s_rst = 1'b0;
    reset = 1'b0;
    drive(0, 1, 0, 0, 4'd0);
    repeat (3) cycle();
    reset = 1'b1; s_rst = 1'b1;

    // Up count: 30 enabled cycles from 0 yield exactly one terminal count.
    drive(1, 1, 0, 0, 4'd0);
    cnt = 0;
    repeat (30) begin cycle(); if (if0.tc) cnt++; end
    check("up_wrap_tc_count", 32'(cnt), 32'd1);
    check("up_wrap_q", 32'(if0.q), 32'd0);

    // Asynchronous reset mid-count at q=7.
    n = 0;
    while (mq[0] != 7 && n < 100) begin cycle(); n++; end
    check("reach_q7", 32'(if0.q), 32'd7);
    reset = 1'b0;
    #1;
    check("async_rst_q0", 32'(if0.q), 32'd0);
    check("async_rst_tc0", 32'(if0.tc), 32'd0);
    check("async_rst_q2", 32'(if2.q), 32'd0);
    for (int i = 0; i < 3; i++) begin sb[i].delete(); mq[i] = 0; mp[i] = 0; mtc[i] = 0; end
    s_rst = 1'b0;
    repeat (2) cycle();
    reset = 1'b1; s_rst = 1'b1;
    cycle(); check("rst_rel_edge1", 32'(if0.q), 32'd0);
    cycle(); check("rst_rel_edge2", 32'(if0.q), 32'd0);
    cycle(); check("rst_rel_edge3", 32'(if0.q), 32'd1);

    // Down wrap from zero.
    drive(1, 0, 0, 1, 4'd0); cycle();
    drive(1, 0, 0, 0, 4'd0);
    repeat (3) cycle();
    check("down_wrap_q", 32'(if0.q), 32'd9);
    check("down_wrap_tc", 32'(if0.tc), 32'd1);
    repeat (6) cycle();
    check("down_q7", 32'(if0.q), 32'd7);

    // Load clamp and clear-over-load priority.
    drive(1, 1, 0, 1, 4'd12); cycle();
    check("load_clamp_m10", 32'(if0.q), 32'd9);
    check("load_noclamp_m16", 32'(if2.q), 32'd12);
    drive(1, 1, 1, 1, 4'd5); cycle();
    check("clr_over_load", 32'(if0.q), 32'd0);

    // Load coinciding with a tick restarts the prescaler.
    drive(1, 1, 0, 0, 4'd0);
    n = 0;
    while (mp[0] != 2 && n < 10) begin cycle(); n++; end
    check("tick_pending", 32'(if0.tick), 32'd1);
    drive(1, 1, 0, 1, 4'd4); cycle();
    check("load_on_tick", 32'(if0.q), 32'd4);
    drive(1, 1, 0, 0, 4'd0);
    repeat (2) cycle();
    check("load_restart_hold", 32'(if0.q), 32'd4);
    cycle();
    check("load_restart_step", 32'(if0.q), 32'd5);

    // Saturate at the top, then step down.
    drive(1, 1, 0, 1, 4'd9); cycle();
    drive(1, 1, 0, 0, 4'd0);
    cnt = 0;
    repeat (12) begin cycle(); if (if1.tc) cnt++; end
    check("sat_tc_pulses", 32'(cnt), 32'd4);
    check("sat_hold_q", 32'(if1.q), 32'd9);
    drive(1, 0, 0, 0, 4'd0);
    repeat (3) cycle();
    check("sat_down_q", 32'(if1.q), 32'd8);
    check("sat_down_tc", 32'(if1.tc), 32'd0);

    // PRESCALE=1 wrap 15 -> 0.
    drive(1, 1, 0, 1, 4'd15); cycle();
    drive(1, 1, 0, 0, 4'd0); cycle();
    check("fast_wrap_q", 32'(if2.q), 32'd0);
    check("fast_wrap_tc", 32'(if2.tc), 32'd1);

    // Enable gap of 5 cycles mid-phase delays the step by exactly 5.
    drive(1, 1, 0, 1, 4'd0); cycle();
    drive(1, 1, 0, 0, 4'd0); cycle();
    n = 1;
    drive(0, 1, 0, 0, 4'd0);
    repeat (5) begin cycle(); n++; end
    drive(1, 1, 0, 0, 4'd0);
    while (if0.q != 4'd1 && n < 20) begin cycle(); n++; end
    check("en_gap_slip", 32'(n), 32'd8);

    // Randomised traffic against the model.
    repeat (400) begin
      drive(($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 11) == 0), 4'($urandom));
      cycle();
    end

    drive(0, 1, 0, 0, 4'd0);
    cycle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
